mul_div_seq: RTL and testbench

//  Parametrised radix-2 sequential arithmetic unit: unsigned/signed multiply giving a full 2*LEN

---
 rtl/mul_div_seq_pkg.sv | 26 ++
 rtl/mul_div_seq_if.sv | 29 ++
 rtl/mul_div_seq_cond_neg.sv | 13 +
 rtl/mul_div_seq.sv | 143 ++++++++++++++
 tb/tb_mul_div_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_seq_pkg.sv
// Shared types for the sequential multiply/divide unit: operation codes,
// FSM states and small mode-decoding helpers.
package mul_div_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MULU = 2'b00,
    MODE_MULS = 2'b01,
    MODE_DIVU = 2'b10,
    MODE_DIVS = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic mode_is_div(input mode_e m);
    return (m == MODE_DIVU) || (m == MODE_DIVS);
  endfunction

  function automatic logic mode_is_signed(input mode_e m);
    return (m == MODE_MULS) || (m == MODE_DIVS);
  endfunction

endpackage

// File: rtl/mul_div_seq_if.sv
// Request/result bundle of the multiply/divide unit; the requester drives
// START/MODE/A/B and the unit returns BUSY/DONE/DZ and the two result halves.
interface mul_div_seq_if
  import mul_div_seq_pkg::*;
#(
  parameter int LEN = 16
) ();

  logic           start;
  mode_e          mode;
  logic [LEN-1:0] a;
  logic [LEN-1:0] b;
  logic           busy;
  logic           done;
  logic           dz;
  logic [LEN-1:0] y_lo;
  logic [LEN-1:0] y_hi;

  modport master (
    output start, mode, a, b,
    input  busy, done, dz, y_lo, y_hi
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, dz, y_lo, y_hi
  );

endinterface

// File: rtl/mul_div_seq_cond_neg.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for restoring result signs.
module cond_neg #(
  parameter int W = 16
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_div_seq.sv
// Radix-2 sequential multiply/divide unit: LEN iterations of shift-add or
// restoring shift-subtract on magnitudes, then one cycle of sign fix-up.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int LEN = 16
) (
  input logic          clk,
  input logic          rst,
  mul_div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(LEN + 1);

  state_e           state;
  mode_e            op_mode;
  logic             sign_a;
  logic             sign_b;
  logic [CNT_W-1:0] cnt;
  logic [2*LEN-1:0] acc;
  logic [LEN-1:0]   opb;
  logic [LEN-1:0]   a_raw;

  logic             req_signed;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [LEN-1:0]   a_mag;
  logic [LEN-1:0]   b_mag;
  logic             op_div;
  logic [LEN:0]     add_sum;
  logic [LEN:0]     shifted;
  logic [LEN:0]     diff;
  logic [2*LEN-1:0] acc_next;
  logic             prod_neg;
  logic             quo_neg;
  logic             rem_neg;
  logic [2*LEN-1:0] prod_fix;
  logic [LEN-1:0]   quo_fix;
  logic [LEN-1:0]   rem_fix;

  assign req_signed = mode_is_signed(bus.mode);
  assign neg_a_in   = req_signed & bus.a[LEN-1];
  assign neg_b_in   = req_signed & bus.b[LEN-1];
  assign op_div     = mode_is_div(op_mode);
  assign prod_neg   = (op_mode == MODE_MULS) & (sign_a ^ sign_b);
  assign quo_neg    = (op_mode == MODE_DIVS) & (sign_a ^ sign_b);
  assign rem_neg    = (op_mode == MODE_DIVS) & sign_a;

  cond_neg #(.W(LEN)) u_abs_a (.neg(neg_a_in), .x(bus.a), .y(a_mag));
  cond_neg #(.W(LEN)) u_abs_b (.neg(neg_b_in), .x(bus.b), .y(b_mag));
  cond_neg #(.W(2*LEN)) u_fix_prod (.neg(prod_neg), .x(acc), .y(prod_fix));
  cond_neg #(.W(LEN)) u_fix_quo (.neg(quo_neg), .x(acc[LEN-1:0]), .y(quo_fix));
  cond_neg #(.W(LEN)) u_fix_rem (.neg(rem_neg), .x(acc[2*LEN-1:LEN]), .y(rem_fix));

  // One radix-2 step; acc holds {partial product | remainder, multiplier | dividend-quotient}.
  always_comb begin
    add_sum  = {1'b0, acc[2*LEN-1:LEN]} + {1'b0, opb};
    shifted  = {acc[2*LEN-1:LEN], acc[LEN-1]};
    diff     = shifted - {1'b0, opb};
    acc_next = acc;
    if (op_div) begin
      if (diff[LEN] == 1'b0) begin
        acc_next = {diff[LEN-1:0], acc[LEN-2:0], 1'b1};
      end else begin
        acc_next = {shifted[LEN-1:0], acc[LEN-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {add_sum, acc[LEN-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*LEN-1:1]};
      end
    end
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_mode  <= MODE_MULU;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      a_raw    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dz   <= 1'b0;
      bus.y_lo <= '0;
      bus.y_hi <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_RUN;
            op_mode  <= bus.mode;
            sign_a   <= neg_a_in;
            sign_b   <= neg_b_in;
            cnt      <= CNT_W'(LEN);
            acc      <= {{LEN{1'b0}}, a_mag};
            opb      <= b_mag;
            a_raw    <= bus.a;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          // The last iteration drives the counter to zero and hands over to FIX.
          if (cnt == CNT_W'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          if (op_div && (opb == {LEN{1'b0}})) begin
            bus.y_lo <= {LEN{1'b1}};
            bus.y_hi <= a_raw;
            bus.dz   <= 1'b1;
          end else if (op_div) begin
            bus.y_lo <= quo_fix;
            bus.y_hi <= rem_fix;
            bus.dz   <= 1'b0;
          end else begin
            bus.y_lo <= prod_fix[LEN-1:0];
            bus.y_hi <= prod_fix[2*LEN-1:LEN];
            bus.dz   <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: an arithmetic reference model plus a
// per-cycle checker of BUSY/DONE timing, held results and reset behaviour.
module tb_mul_div_seq;
  import mul_div_seq_pkg::*;

  localparam int LEN = 16;

  logic clk;
  logic rst;

  mul_div_seq_if #(.LEN(LEN)) bus ();

  mul_div_seq #(.LEN(LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Expected-state bookkeeping written only by the stimulus process.
  bit          op_active;
  int          acc_edge;
  logic [15:0] exp_lo, exp_hi, held_lo, held_hi, lit_lo, lit_hi;
  logic        exp_dz, lit_dz;
  bit          lit_valid;

  // Counters written only by the compare process.
  int vec_cnt = 0;
  int miss_cnt = 0;
  int rel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec_cnt++;
    if (act !== expv) begin
      miss_cnt++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic, truncating toward zero.
  function automatic void model(input mode_e m, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] lo, output logic [15:0] hi, output logic z);
    longint p;
    int sa_i, sb_i, q, r;
    sa_i = $signed(a);
    sb_i = $signed(b);
    z = 1'b0;
    lo = 16'h0000;
    hi = 16'h0000;
    case (m)
      MODE_MULU: begin
        p = longint'(a) * longint'(b);
        lo = p[15:0];
        hi = p[31:16];
      end
      MODE_MULS: begin
        p = longint'(sa_i) * longint'(sb_i);
        lo = p[15:0];
        hi = p[31:16];
      end
      MODE_DIVU: begin
        if (b == 16'h0000) begin
          lo = 16'hFFFF; hi = a; z = 1'b1;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: begin
        if (b == 16'h0000) begin
          lo = 16'hFFFF; hi = a; z = 1'b1;
        end else begin
          q = sa_i / sb_i;
          r = sa_i % sb_i;
          lo = q[15:0];
          hi = r[15:0];
        end
      end
    endcase
  endfunction

  // Compare process: every falling edge, outputs versus the expected state.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dz",   32'(bus.dz),   32'd0);
      chk("rst_y_lo", 32'(bus.y_lo), 32'd0);
      chk("rst_y_hi", 32'(bus.y_hi), 32'd0);
    end else if (!op_active) begin
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_y_lo", 32'(bus.y_lo), 32'd0);
      chk("idle_y_hi", 32'(bus.y_hi), 32'd0);
    end else begin
      rel = edge_n - acc_edge + 1;
      if (rel <= LEN + 1) begin
        chk("run_busy", 32'(bus.busy), 32'd1);
        chk("run_done", 32'(bus.done), 32'd0);
        chk("run_dz",   32'(bus.dz),   32'd0);
        chk("run_held_lo", 32'(bus.y_lo), 32'(held_lo));
        chk("run_held_hi", 32'(bus.y_hi), 32'(held_hi));
      end else begin
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_level", 32'(bus.done), 32'd1);
        chk("y_lo", 32'(bus.y_lo), 32'(exp_lo));
        chk("y_hi", 32'(bus.y_hi), 32'(exp_hi));
        chk("dz",   32'(bus.dz),   32'(exp_dz));
        if (lit_valid) begin
          chk("model_pin_lo", 32'(exp_lo), 32'(lit_lo));
          chk("model_pin_hi", 32'(exp_hi), 32'(lit_hi));
          chk("model_pin_dz", 32'(exp_dz), 32'(lit_dz));
        end
      end
    end
  end

  task automatic accept(input mode_e m, input logic [15:0] a, input logic [15:0] b,
                        input bit pin, input logic [15:0] pl, input logic [15:0] ph, input logic pz);
    logic [15:0] lo, hi;
    logic z;
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    model(m, a, b, lo, hi, z);
    held_lo   = op_active ? exp_lo : 16'h0000;
    held_hi   = op_active ? exp_hi : 16'h0000;
    exp_lo    = lo;
    exp_hi    = hi;
    exp_dz    = z;
    lit_valid = pin;
    lit_lo    = pl;
    lit_hi    = ph;
    lit_dz    = pz;
    acc_edge  = edge_n;
    op_active = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  task automatic run_op(input mode_e m, input logic [15:0] a, input logic [15:0] b,
                        input bit pin, input logic [15:0] pl, input logic [15:0] ph,
                        input logic pz, input bit poke);
    int waited;
    accept(m, a, b, pin, pl, ph, pz);
    waited = 0;
    while (!bus.done && waited < LEN + 4) begin
      if (poke && waited == 3) begin
        bus.start = 1'b1;
        bus.mode  = MODE_DIVS;
        bus.a     = 16'h7777;
        bus.b     = 16'h0003;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = MODE_MULU;
    bus.a     = 16'h0000;
    bus.b     = 16'h0000;
    op_active = 1'b0;
    lit_valid = 1'b0;
    acc_edge  = 0;
    exp_lo = 16'h0000; exp_hi = 16'h0000; exp_dz = 1'b0;
    held_lo = 16'h0000; held_hi = 16'h0000;
    lit_lo = 16'h0000; lit_hi = 16'h0000; lit_dz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(MODE_MULU, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
    run_op(MODE_MULS, 16'hFFFD, 16'h0005, 1'b1, 16'hFFF1, 16'hFFFF, 1'b0, 1'b0);
    run_op(MODE_MULS, 16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h4000, 1'b0, 1'b0);
    run_op(MODE_DIVU, 16'd100,  16'd7,    1'b1, 16'h000E, 16'h0002, 1'b0, 1'b0);
    run_op(MODE_DIVS, 16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    run_op(MODE_DIVS, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0);
    run_op(MODE_DIVU, 16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
    run_op(MODE_DIVS, 16'hFFF0, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF0, 1'b1, 1'b0);
    run_op(MODE_MULU, 16'h0000, 16'hABCD, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Extra START mid-operation must be ignored.
    run_op(MODE_MULU, 16'h1234, 16'h00FF, 1'b1, 16'h21CC, 16'h0012, 1'b0, 1'b1);

    // Result must stay on the outputs while idle.
    repeat (3) @(posedge clk);
    #1;

    // Abort an operation with reset at cycle 5, then issue a fresh one.
    accept(MODE_DIVU, 16'hBEEF, 16'h0013, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst       = 1'b1;
    op_active = 1'b0;
    lit_valid = 1'b0;
    exp_lo = 16'h0000; exp_hi = 16'h0000; exp_dz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(MODE_MULS, 16'h7FFF, 16'h7FFF, 1'b1, 16'h0001, 16'h3FFF, 1'b0, 1'b0);
    run_op(MODE_DIVS, 16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0);

    // Back-to-back hashed regression across all modes.
    for (int md = 0; md < 4; md++) begin
      for (int i = 0; i < 100; i++) begin
        run_op(mode_e'(md), 16'(i * 193), 16'(i * 1543), 1'b0,
               16'h0000, 16'h0000, 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
